// File: rtl/alien_scheduler_pkg.sv
// alien_scheduler_pkg: shared VGA timing constants, alien/slot types and window helpers
// Revision: 1.0
`default_nettype none

package alien_scheduler_pkg;

    localparam int H_VISIBLE   = 640;
    localparam int H_TOTAL     = 800;
    localparam int V_VISIBLE   = 480;
    localparam int V_TOTAL     = 525;
    localparam int SPRITE_HALF = 32;
    localparam int SLOT_IDX_W  = 8;

    typedef struct packed {
        logic [9:0] _x_pos;
        logic [9:0] _y_pos;
        logic [4:0] _r;
    } AlienData;

    typedef struct packed {
        logic                  valid;
        logic [SLOT_IDX_W-1:0] idx;
        AlienData              data;
    } SlotEntry;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_SCAN  = 2'd2,
        S_DONE  = 2'd3
    } sched_state_e;

    // Windows are evaluated in 11-bit signed space so they clip at 0 instead of wrapping.
    function automatic logic signed [10:0] half_size(input logic [4:0] r);
        logic [9:0] hs;
        hs = 10'(SPRITE_HALF) - {5'd0, r};
        return $signed({1'b0, hs});
    endfunction

    function automatic logic h_hit(input logic [9:0] h, input AlienData a);
        logic signed [10:0] hs;
        logic signed [10:0] pos;
        logic signed [10:0] cnt;
        hs  = half_size(a._r);
        pos = $signed({1'b0, a._x_pos});
        cnt = $signed({1'b0, h});
        return (cnt > pos - hs) && (cnt < pos + hs);
    endfunction

    function automatic logic v_hit(input logic [9:0] line, input AlienData a);
        logic signed [10:0] hs;
        logic signed [10:0] pos;
        logic signed [10:0] ln;
        hs  = half_size(a._r);
        pos = $signed({1'b0, a._y_pos});
        ln  = $signed({1'b0, line});
        return (ln >= pos - hs) && (ln < pos + hs);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alien_scheduler_if.sv
// alien_scheduler_if: alien list in, selected alien out, between game state and renderer
// Revision: 1.0
`default_nettype none

interface alien_scheduler_if #(
    parameter int MAX_ALIENS = 8
);
    import alien_scheduler_pkg::*;

    localparam int IDX_W = (MAX_ALIENS > 1) ? $clog2(MAX_ALIENS) : 1;

    logic [9:0]            h_cnt;
    logic [9:0]            v_cnt;
    AlienData              alien_list [MAX_ALIENS];
    logic [MAX_ALIENS-1:0] alien_en;
    AlienData              sel_data;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_hit;
    logic                  line_overflow;

    modport master (
        output h_cnt, v_cnt, alien_list, alien_en,
        input  sel_data, sel_idx, sel_hit, line_overflow
    );

    modport slave (
        input  h_cnt, v_cnt, alien_list, alien_en,
        output sel_data, sel_idx, sel_hit, line_overflow
    );

endinterface

`default_nettype wire

// File: rtl/alien_scheduler_slot_picker.sv
// alien_slot_picker: picks the nearest (smallest radius) slot covering h_cnt; ties go to the lowest slot
// Revision: 1.0
`default_nettype none

module alien_slot_picker
    import alien_scheduler_pkg::*;
#(
    parameter int SLOTS = 4
) (
    input  logic [9:0]            h_cnt_i,
    input  SlotEntry              slots_i [SLOTS],
    output logic                  hit_o,
    output AlienData              data_o,
    output logic [SLOT_IDX_W-1:0] idx_o
);

    logic                  found;
    AlienData              best_data;
    logic [SLOT_IDX_W-1:0] best_idx;

    always_comb begin
        found     = 1'b0;
        best_data = '0;
        best_idx  = '0;
        for (int s = 0; s < SLOTS; s++) begin
            if (slots_i[s].valid && h_hit(h_cnt_i, slots_i[s].data) &&
                (!found || (slots_i[s].data._r < best_data._r))) begin
                found     = 1'b1;
                best_data = slots_i[s].data;
                best_idx  = slots_i[s].idx;
            end
        end
    end

    assign hit_o  = found;
    assign data_o = best_data;
    assign idx_o  = best_idx;

endmodule

`default_nettype wire

// File: rtl/alien_scheduler.sv
// alien_scheduler: scans the alien list in h-blank into a shadow slot table, swaps it in at line end,
// and selects the nearest covering alien per pixel with one cycle of latency.
`default_nettype none

module alien_scheduler
    import alien_scheduler_pkg::*;
#(
    parameter int MAX_ALIENS = 8,
    parameter int SLOTS      = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alien_scheduler_if.slave bus
);

    localparam int IDX_W = (MAX_ALIENS > 1) ? $clog2(MAX_ALIENS) : 1;
    localparam int WP_W  = $clog2(SLOTS + 1);

    generate
        if (2 + MAX_ALIENS > 159) begin : g_budget_err
            $error("alien_scheduler: MAX_ALIENS scan does not fit in horizontal blanking");
        end
    endgenerate

    sched_state_e          state_q, state_d;
    logic                  clear_shadow, scan_en, swap_en;
    logic [IDX_W-1:0]      scan_i_q;
    logic [WP_W-1:0]       wp_q;
    SlotEntry              shadow_q [SLOTS];
    SlotEntry              active_q [SLOTS];
    logic                  ovf_q;
    logic                  sel_hit_q;
    AlienData              sel_data_q;
    logic [IDX_W-1:0]      sel_idx_q;

    logic [9:0]            next_line;
    AlienData              cur_entry;
    logic                  cur_hit, slot_free, ovf_set, frame_start, visible, scan_last;
    logic                  pick_hit;
    AlienData              pick_data;
    logic [SLOT_IDX_W-1:0] pick_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.h_cnt == 10'(H_VISIBLE)) state_d = S_CLEAR;
            S_CLEAR: state_d = S_SCAN;
            S_SCAN:  if (scan_last) state_d = S_DONE;
            S_DONE:  if (bus.h_cnt == 10'(H_TOTAL - 1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        clear_shadow = (state_q == S_CLEAR);
        scan_en      = (state_q == S_SCAN);
        swap_en      = (state_q == S_DONE) && (bus.h_cnt == 10'(H_TOTAL - 1));
    end

    // The scan during line v fills the table for line v+1, wrapping to 0 after the last line.
    assign next_line   = (bus.v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : bus.v_cnt + 10'd1;
    assign scan_last   = (scan_i_q == IDX_W'(MAX_ALIENS - 1));
    assign cur_entry   = bus.alien_list[scan_i_q];
    assign cur_hit     = scan_en && bus.alien_en[scan_i_q] && v_hit(next_line, cur_entry);
    assign slot_free   = (wp_q < WP_W'(SLOTS));
    assign ovf_set     = cur_hit && !slot_free;
    assign frame_start = (bus.h_cnt == 10'd0) && (bus.v_cnt == 10'd0);
    assign visible     = (bus.h_cnt < 10'(H_VISIBLE)) && (bus.v_cnt < 10'(V_VISIBLE));

    alien_slot_picker #(.SLOTS(SLOTS)) u_picker (
        .h_cnt_i (bus.h_cnt),
        .slots_i (active_q),
        .hit_o   (pick_hit),
        .data_o  (pick_data),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SLOTS; s++) begin
                shadow_q[s] <= '0;
                active_q[s] <= '0;
            end
            wp_q       <= '0;
            scan_i_q   <= '0;
            ovf_q      <= 1'b0;
            sel_hit_q  <= 1'b0;
            sel_data_q <= '0;
            sel_idx_q  <= '0;
        end else begin
            if (clear_shadow) begin
                for (int s = 0; s < SLOTS; s++) shadow_q[s].valid <= 1'b0;
                wp_q     <= '0;
                scan_i_q <= '0;
            end
            if (scan_en) scan_i_q <= scan_i_q + IDX_W'(1);
            if (cur_hit && slot_free) begin
                for (int s = 0; s < SLOTS; s++) begin
                    if (wp_q == WP_W'(s))
                        shadow_q[s] <= '{valid: 1'b1, idx: SLOT_IDX_W'(scan_i_q), data: cur_entry};
                end
                wp_q <= wp_q + WP_W'(1);
            end
            if (swap_en) begin
                for (int s = 0; s < SLOTS; s++) active_q[s] <= shadow_q[s];
            end
            // Set takes priority over the frame-start clear.
            if (ovf_set)          ovf_q <= 1'b1;
            else if (frame_start) ovf_q <= 1'b0;
            sel_hit_q <= pick_hit && visible;
            if (pick_hit) begin
                sel_data_q <= pick_data;
                sel_idx_q  <= IDX_W'(pick_idx);
            end
        end
    end

    assign bus.sel_hit       = sel_hit_q;
    assign bus.sel_data      = sel_data_q;
    assign bus.sel_idx       = sel_idx_q;
    assign bus.line_overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_alien_scheduler.sv
// tb_alien_scheduler: directed vector table plus hand sequences for overflow, hold and reset behaviour.
`default_nettype none

module tb_alien_scheduler;
    import alien_scheduler_pkg::*;

    localparam int NA = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alien_scheduler_if #(.MAX_ALIENS(NA)) bus();

    alien_scheduler #(.MAX_ALIENS(NA), .SLOTS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int scn;
        int v;
        int h;
        int hit;
        int idx;
        int chk_idx;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read 1 unit after the rising edge.
    task automatic tick(input int h, input int v);
        @(negedge clk);
        bus.h_cnt = 10'(h);
        bus.v_cnt = 10'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic prep_line(input int l);
        int pv;
        pv = (l == 0) ? 524 : l - 1;
        for (int h = 640; h < 800; h++) tick(h, pv);
    endtask

    task automatic set_alien(input int i, input int x, input int y, input int r);
        bus.alien_list[i] = '{_x_pos: 10'(x), _y_pos: 10'(y), _r: 5'(r)};
        bus.alien_en[i]   = 1'b1;
    endtask

    task automatic load_scn(input int s);
        for (int i = 0; i < NA; i++) bus.alien_list[i] = '0;
        bus.alien_en = '0;
        case (s)
            0: set_alien(0, 100, 100, 0);
            1: begin set_alien(0, 200, 200, 8); set_alien(1, 200, 200, 2); end
            2: begin set_alien(0, 200, 200, 2); set_alien(1, 200, 200, 2); end
            3: set_alien(0, 10, 10, 0);
            4: set_alien(0, 630, 470, 0);
            5: for (int i = 0; i < 6; i++) set_alien(i, 100 * (i + 1), 50, 0);
            6: set_alien(0, 400, 100, 0);
            7: begin set_alien(0, 100, 100, 0); bus.alien_en = '0; end
            default: ;
        endcase
    endtask

    task automatic add(input int s, input int v, input int h, input int hit, input int idx, input int ci);
        vec_t t;
        t = '{s, v, h, hit, idx, ci};
        vecs.push_back(t);
    endtask

    initial begin
        int cur_scn;
        int cur_v;
        int hits_after;

        rst_n     = 1'b0;
        bus.h_cnt = '0;
        bus.v_cnt = '0;
        load_scn(-1);

        // Reset values
        tick(0, 0);
        tick(1, 0);
        check("rst_sel_hit", int'(bus.sel_hit), 0);
        check("rst_sel_idx", int'(bus.sel_idx), 0);
        check("rst_sel_data", int'(bus.sel_data), 0);
        check("rst_overflow", int'(bus.line_overflow), 0);
        rst_n = 1'b1;

        // Nothing drawn before the first swap
        load_scn(0);
        tick(100, 100);
        check("no_swap_yet", int'(bus.sel_hit), 0);

        // scn, line, h, hit, idx, check idx
        add(0, 100, 100, 1, 0, 1);
        add(0, 100,  69, 1, 0, 1);
        add(0, 100, 131, 1, 0, 1);
        add(0, 100,  68, 0, 0, 0);
        add(0, 100, 132, 0, 0, 0);
        add(0,  68, 100, 1, 0, 1);
        add(0,  67, 100, 0, 0, 0);
        add(0, 131, 100, 1, 0, 1);
        add(0, 132, 100, 0, 0, 0);
        add(1, 200, 200, 1, 1, 1);
        add(1, 200, 180, 1, 1, 1);
        add(1, 200, 172, 1, 1, 1);
        add(2, 200, 200, 1, 0, 1);
        add(3,  10,   0, 1, 0, 1);
        add(3,  10,  41, 1, 0, 1);
        add(3,  10,  42, 0, 0, 0);
        add(3,  10, 790, 0, 0, 0);
        add(3,   0,  10, 1, 0, 1);
        add(3, 520,  10, 0, 0, 0);
        add(4, 470, 635, 1, 0, 1);
        add(4, 470, 645, 0, 0, 0);
        add(4, 479, 639, 1, 0, 1);
        add(4, 490, 635, 0, 0, 0);
        add(5,  50, 100, 1, 0, 1);
        add(5,  50, 300, 1, 2, 1);
        add(5,  50, 400, 1, 3, 1);
        add(5,  50, 500, 0, 0, 0);
        add(5,  50, 600, 0, 0, 0);
        add(7, 100, 100, 0, 0, 0);

        cur_scn = -1;
        cur_v   = -1;
        foreach (vecs[k]) begin
            if (vecs[k].scn != cur_scn) begin
                load_scn(vecs[k].scn);
                cur_scn = vecs[k].scn;
                cur_v   = -1;
            end
            if (vecs[k].v != cur_v) begin
                prep_line(vecs[k].v);
                cur_v = vecs[k].v;
            end
            tick(vecs[k].h, vecs[k].v);
            check($sformatf("vec%0d_hit(v=%0d,h=%0d)", k, vecs[k].v, vecs[k].h),
                  int'(bus.sel_hit), vecs[k].hit);
            if (vecs[k].chk_idx != 0)
                check($sformatf("vec%0d_idx(v=%0d,h=%0d)", k, vecs[k].v, vecs[k].h),
                      int'(bus.sel_idx), vecs[k].idx);
        end

        // Selection holds data/idx when nothing covers the pixel
        load_scn(1);
        prep_line(200);
        tick(200, 200);
        check("hold_pre_idx", int'(bus.sel_idx), 1);
        tick(300, 200);
        check("hold_hit", int'(bus.sel_hit), 0);
        check("hold_idx", int'(bus.sel_idx), 1);
        check("hold_data_r", int'(bus.sel_data._r), 2);
        check("hold_data_x", int'(bus.sel_data._x_pos), 200);

        // Overflow is sticky until frame start
        tick(5, 0);
        load_scn(5);
        prep_line(50);
        check("ovf_set", int'(bus.line_overflow), 1);
        tick(400, 50);
        check("ovf_line_idx3", int'(bus.sel_idx), 3);
        prep_line(0);
        check("ovf_sticky", int'(bus.line_overflow), 1);
        tick(0, 0);
        check("ovf_cleared", int'(bus.line_overflow), 0);

        // Reset mid-line blanks the rest of the line; next line recovers
        load_scn(6);
        prep_line(100);
        tick(400, 100);
        check("prerst_hit", int'(bus.sel_hit), 1);
        tick(299, 100);
        rst_n = 1'b0;
        tick(300, 100);
        rst_n = 1'b1;
        check("rst_midline_hit", int'(bus.sel_hit), 0);
        hits_after = 0;
        for (int h = 301; h < 640; h++) begin
            tick(h, 100);
            if (bus.sel_hit === 1'b1) hits_after++;
        end
        check("postrst_line_hits", hits_after, 0);
        for (int h = 640; h < 800; h++) tick(h, 100);
        tick(400, 101);
        check("postrst_next_hit", int'(bus.sel_hit), 1);
        check("postrst_next_idx", int'(bus.sel_idx), 0);

        // Partial scan interrupted by reset is never swapped in
        for (int h = 640; h < 644; h++) tick(h, 101);
        rst_n = 1'b0;
        tick(644, 101);
        rst_n = 1'b1;
        for (int h = 645; h < 800; h++) tick(h, 101);
        tick(400, 102);
        check("partial_scan_hit", int'(bus.sel_hit), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alien_scheduler.md
# alien_scheduler

Per-scanline sprite scheduler for the alien layer. During each horizontal blanking interval it scans the alien list and records in a shadow slot table which aliens intersect the next scanline. During the visible region it selects, pixel by pixel, the nearest alien covering `h_cnt` and presents its `AlienData` to `alien_renderer`. It sits between the game-state alien list and the renderer/ROM path, so one renderer and one sprite ROM serve every alien.

## Interface
- `MAX_ALIENS`, default 8: entries in the alien list.
- `SLOTS`, default 4: aliens renderable on one scanline.
- `clk` input 1: 25 MHz pixel clock. `h_cnt` advances once per cycle.
- `rst_n` input 1: reset, synchronous, active-low.
- `h_cnt` input 10: VGA horizontal counter, 0..799.
- `v_cnt` input 10: VGA vertical counter, 0..524.
- `alien_list` input `AlienData [MAX_ALIENS]`: current alien states. Must be stable during blanking.
- `alien_en` input `MAX_ALIENS`: per-entry live mask.
- `sel_data` output `AlienData`: selected alien for the renderer.
- `sel_idx` output `$clog2(MAX_ALIENS)`: list index of the selected alien.
- `sel_hit` output 1: `sel_data` is meaningful for this pixel.
- `line_overflow` output 1: sticky flag, set when more than `SLOTS` aliens intersect one line. Cleared at frame start.

## Operation
- Half-size: `hs = 32 - _r`, 10-bit unsigned.
- Vertical hit: `_y_pos - hs <= L < _y_pos + hs`, where L is the next line. L is `v_cnt+1`, or 0 when `v_cnt==V_TOTAL-1`.
- Horizontal hit: `|h_cnt - _x_pos| < hs`.
- All window comparisons use 11-bit signed arithmetic, so windows that cross edge 0 clip correctly instead of wrapping.
- Two slot tables, active and shadow. Each slot holds `valid`, `idx` and a copy of `AlienData`.
- FSM:
  - IDLE: waits for `h_cnt==H_VISIBLE` (640), then goes to CLEAR.
  - CLEAR: one cycle. Invalidates every shadow slot and zeroes the write pointer `wp`. Goes to SCAN.
  - SCAN: examines one list entry `i` per cycle, for i = 0..MAX_ALIENS-1.
    - If `alien_en[i]` and vertical hit: when `wp<SLOTS`, write the entry to `shadow[wp]` and increment `wp`; otherwise set `line_overflow` and drop the entry.
    - After the last entry, goes to DONE.
  - DONE: waits for `h_cnt==H_TOTAL-1`. On that cycle it copies shadow into active and returns to IDLE.
- Pixel selection happens every cycle, from the active table only:
  - Candidates are valid slots with a horizontal hit.
  - Winner: smallest `_r` (nearest). Ties go to the lowest slot number, which is list order.
  - If there is no candidate: `sel_hit=0`, and `sel_data`/`sel_idx` hold their previous values.
- Visibility gate: `sel_hit` is forced to 0 when `h_cnt>=H_VISIBLE` or `v_cnt>=V_VISIBLE`.
- `line_overflow` clears on the cycle where `h_cnt==0 && v_cnt==0`. If an overflow occurs in that same cycle, set wins over clear.

## Timing
- Selection latency is 1 cycle: the output registered at edge t+1 corresponds to the `h_cnt`/`v_cnt` sampled at edge t. The consumer delays its counters by 1 cycle.
- Scan budget is 2 + MAX_ALIENS cycles. This must be ≤ 159, the blanking length minus the swap cycle; checked by elaboration assertion.
- `alien_list` changes during active video do not affect the current line. Changes during SCAN may yield a mixed snapshot; the producer updates only during vertical blanking.
- Reset values: FSM=IDLE, both tables invalid, `wp=0`, `sel_hit=0`, `sel_data='0`, `sel_idx=0`, `line_overflow=0`.
- Reset asserted mid-line takes effect on the next edge. Nothing is drawn until the first swap following a full scan. A partial scan is never swapped in.

## Structure
- Shared package additions:
  - Constants: `H_VISIBLE=640`, `H_TOTAL=800`, `V_VISIBLE=480`, `V_TOTAL=525`, `SPRITE_HALF=32`.
  - Typedefs: the `AlienData` fields (already present), a new `SlotEntry` struct, and the scheduler state enum.
- One sub-module, `alien_slot_picker`: combinational nearest-hit selection across `SLOTS` entries. It is reused for every pixel cycle.

## Test plan
- Single alien (`x=100,y=100,r=0`), enabled: on line 100, `sel_hit=1` one cycle after `h_cnt` ∈ 69..131; 0 at h=68 and h=132; `sel_idx=0`.
- Overlap: alien0 `r=8` and alien1 `r=2`, both `x=200,y=200`. At (200,200), `sel_idx=1`; with equal `r`, `sel_idx=0`.
- Overflow: 6 aliens all at `y=50`, SLOTS=4. On line 50 only indices 0..3 are ever selected, and `line_overflow=1` until the next frame start, then 0.
- Edge clipping: alien `x=10,y=10,r=0`. `sel_hit=1` at h=0 and at v=0. No hit at h=790 or v=520, i.e. no wrap.
- Frame wrap: at `v_cnt=524` the scan builds line 0; an alien covering line 0 appears on line 0.
- Reset: assert `rst_n=0` at `h_cnt=300`, release on the same line. `sel_hit=0` for the rest of that line; the next line renders normally after its scan completes.
